// File: rtl/i2s_adc_rx.sv
// rtl/i2s_adc_rx.sv - I2S ADC capture: oversampled bclk/adclrc/adcdat, MSB-first deserializer, stereo pair handshake
module i2s_adc_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  bclk,
    input  logic                  adclrc,
    input  logic                  adcdat,
    output logic [DATA_WIDTH-1:0] out_left,
    output logic [DATA_WIDTH-1:0] out_right,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrc_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_bclk_d;
    logic                   r_lrc_prev;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [DATA_WIDTH-1:0]  r_left_hold;
    logic                   r_left_ok;

    logic                   w_bclk_s;
    logic                   w_lrc_s;
    logic                   w_dat_s;
    logic                   w_rise;
    logic                   w_boundary;
    logic                   w_last;
    logic [DATA_WIDTH-1:0]  w_word;

    // All three inputs share the same synchronizer depth so they stay aligned.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_bclk_sync <= '0;
            r_lrc_sync  <= '0;
            r_dat_sync  <= '0;
            r_bclk_d    <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], bclk};
            r_lrc_sync  <= {r_lrc_sync[SYNC_STAGES-2:0], adclrc};
            r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], adcdat};
            r_bclk_d    <= r_bclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_bclk_s   = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrc_s    = r_lrc_sync[SYNC_STAGES-1];
    assign w_dat_s    = r_dat_sync[SYNC_STAGES-1];
    assign w_rise     = w_bclk_s & ~r_bclk_d;
    assign w_boundary = w_rise & (w_lrc_s != r_lrc_prev);
    assign w_last     = (r_cnt == CW'(DATA_WIDTH - 1));
    assign w_word     = {r_shift[DATA_WIDTH-2:0], w_dat_s};

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_lrc_prev  <= 1'b0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_left_ok   <= 1'b0;
            out_left    <= '0;
            out_right   <= '0;
            out_valid   <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (w_rise)
                r_lrc_prev <= w_lrc_s;
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_boundary && !w_lrc_s) begin
                        r_state   <= SHIFT;
                        r_cnt     <= '0;
                        r_shift   <= '0;
                        r_left_ok <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_boundary) begin
                        // Short slot: partial word dropped, pair invalidated.
                        frame_err <= 1'b1;
                        r_left_ok <= 1'b0;
                        r_cnt     <= '0;
                        r_shift   <= '0;
                    end else if (w_rise) begin
                        r_shift <= w_word;
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= WAIT;
                            if (!w_lrc_s) begin
                                r_left_hold <= w_word;
                                r_left_ok   <= 1'b1;
                            end else if (r_left_ok) begin
                                out_left  <= r_left_hold;
                                out_right <= w_word;
                                out_valid <= 1'b1;
                                r_left_ok <= 1'b0;
                                if (out_valid && !out_ready)
                                    overrun <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (w_boundary) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        if (!w_lrc_s)
                            r_left_ok <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb/tb_i2s_adc_rx.sv - scoreboard bench for i2s_adc_rx
module tb_i2s_adc_rx;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        bclk = 1'b0;
    logic        adclrc = 1'b0;
    logic        adcdat = 1'b0;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        frame_err;
    logic        overrun;

    int tests = 0;
    int errors = 0;
    int n_acc = 0;
    int n_vcyc = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    logic [31:0] q[$];

    i2s_adc_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .mclk(mclk), .rst(rst), .bclk(bclk), .adclrc(adclrc), .adcdat(adcdat),
        .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
        .out_ready(out_ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 mclk = ~mclk;

    // Output monitor: pops the scoreboard on every accepted pair.
    always @(negedge mclk) begin
        if (!rst) begin
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (out_valid) n_vcyc++;
            if (out_valid && out_ready) begin
                logic [31:0] exp_pair;
                n_acc++;
                tests++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pair: got %h/%h, none expected", out_left, out_right);
                end else begin
                    exp_pair = q.pop_front();
                    if ({out_left, out_right} !== exp_pair) begin
                        errors++;
                        $display("FAIL pair_data: got %h/%h expected %h/%h",
                                 out_left, out_right, exp_pair[31:16], exp_pair[15:0]);
                    end
                end
            end
        end
    end

    task automatic drive_bit(input logic lrc, input logic dat);
        bclk = 1'b0; adclrc = lrc; adcdat = dat;
        #40;
        bclk = 1'b1;
        #40;
    endtask

    task automatic slot(input logic lrc, input logic [15:0] word, input int len);
        logic d;
        for (int i = 0; i < len; i++) begin
            if (i >= 1 && i <= 16) d = word[16-i];
            else d = 1'($urandom_range(0, 1));
            drive_bit(lrc, d);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        slot(1'b0, l, 32);
        slot(1'b1, r, 32);
    endtask

    task automatic preamble();
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge mclk); #1;
        out_ready = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge mclk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        tests++;
        if ({out_valid, frame_err, overrun} !== 3'b000 || out_left !== 16'h0 || out_right !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b fe=%b ov=%b %h/%h expected all 0",
                     out_valid, frame_err, overrun, out_left, out_right);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_standard();
        int a0 = n_acc, v0 = n_vcyc, f0 = n_ferr, o0 = n_ovr;
        out_ready = 1'b1;
        preamble();
        q.push_back({16'hA5C3, 16'h1234});
        send_frame(16'hA5C3, 16'h1234);
        idle(8);
        check_int("std_accepts", n_acc - a0, 1);
        check_int("std_valid_cycles", n_vcyc - v0, 1);
        check_int("std_frame_err", n_ferr - f0, 0);
        check_int("std_overrun", n_ovr - o0, 0);
    endtask

    task automatic test_back_to_back();
        int a0 = n_acc, v0 = n_vcyc;
        logic [15:0] l, r;
        for (int k = 0; k < 10; k++) begin
            l = 16'($urandom); r = 16'($urandom);
            if (k == 0) begin l = 16'hFFFF; r = 16'h0000; end
            q.push_back({l, r});
            send_frame(l, r);
        end
        idle(8);
        check_int("b2b_accepts", n_acc - a0, 10);
        check_int("b2b_valid_cycles", n_vcyc - v0, 10);
    endtask

    task automatic test_overrun();
        int a0 = n_acc, o0 = n_ovr;
        set_ready(1'b0);
        send_frame(16'h8000, 16'h0001);
        q.push_back({16'h7FFF, 16'hFFFF});
        send_frame(16'h7FFF, 16'hFFFF);
        idle(4);
        check_int("ovr_pulses", n_ovr - o0, 1);
        tests++;
        if (out_valid !== 1'b1 || out_left !== 16'h7FFF || out_right !== 16'hFFFF) begin
            errors++;
            $display("FAIL ovr_held: got v=%b %h/%h expected 1 7fff/ffff", out_valid, out_left, out_right);
        end
        check_int("ovr_no_accept_yet", n_acc - a0, 0);
        set_ready(1'b1);
        idle(6);
        check_int("ovr_accepts", n_acc - a0, 1);
        check_int("ovr_valid_after", int'(out_valid), 0);
    endtask

    task automatic test_frame_err();
        int a0 = n_acc, f0 = n_ferr, v0 = n_vcyc;
        slot(1'b0, 16'hBEEF, 11);
        slot(1'b1, 16'h5555, 32);
        idle(4);
        check_int("ferr_pulses", n_ferr - f0, 1);
        check_int("ferr_no_valid", n_vcyc - v0, 0);
        q.push_back({16'h0F0F, 16'hF00D});
        send_frame(16'h0F0F, 16'hF00D);
        idle(6);
        check_int("ferr_recover_accepts", n_acc - a0, 1);
    endtask

    task automatic test_reset_right_slot();
        int a0 = n_acc;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 3) rst = 1'b0;
            drive_bit(1'b1, (i >= 1 && i <= 16) ? 1'b1 : 1'b0);
        end
        idle(4);
        check_int("rslot_nothing", n_acc - a0, 0);
        q.push_back({16'h1357, 16'h2468});
        send_frame(16'h1357, 16'h2468);
        idle(6);
        check_int("rslot_accepts", n_acc - a0, 1);
    endtask

    task automatic test_async_reset();
        int a0 = n_acc;
        set_ready(1'b0);
        send_frame(16'hDEAD, 16'hC0DE);
        for (int i = 0; i < 7; i++) drive_bit(1'b0, 1'b1);
        tests++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ares_pre_valid: got %b expected 1", out_valid);
        end
        @(posedge mclk); #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({out_valid, frame_err, overrun} !== 3'b000 || out_left !== 16'h0 || out_right !== 16'h0) begin
            errors++;
            $display("FAIL ares_outputs: got v=%b fe=%b ov=%b %h/%h expected all 0",
                     out_valid, frame_err, overrun, out_left, out_right);
        end
        @(posedge mclk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        preamble();
        q.push_back({16'h4242, 16'h9876});
        send_frame(16'h4242, 16'h9876);
        idle(6);
        check_int("ares_accepts", n_acc - a0, 1);
    endtask

    initial begin
        @(posedge mclk); #1;
        test_reset();
        test_standard();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_reset_right_slot();
        test_async_reset();
        check_int("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/i2s_adc_rx.md
Name: i2s_adc_rx

Overview:
- I2S capture stage sitting directly downstream of the codec ADC pins (bclk, adclrc, adcdat) inside top.
- Runs entirely on mclk: oversamples bclk, adclrc and adcdat, deserializes MSB-first words and assembles left/right stereo pairs.
- Presents each completed pair to the audio processing path through a valid/ready handshake.
- Flags short frames and overruns.

Parameters:
- DATA_WIDTH, 16: bits captured per channel, MSB first; later bits in the slot are ignored.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers; minimum 2.

Ports:
- mclk  input  1  system clock (12.288 MHz); all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- bclk  input  1  codec bit clock, asynchronous to mclk, at most mclk/4.
- adclrc  input  1  codec word select: 0 = left, 1 = right; changes on bclk falling edge.
- adcdat  input  1  codec serial data; changes on bclk falling edge.
- out_left  output  DATA_WIDTH  left sample of the current pair.
- out_right  output  DATA_WIDTH  right sample of the current pair.
- out_valid  output  1  pair available; held until accepted.
- out_ready  input  1  consumer accepts the pair when out_valid and out_ready are both high on an mclk edge.
- frame_err  output  1  one-mclk pulse when a channel slot ends before DATA_WIDTH bits are captured.
- overrun  output  1  one-mclk pulse when a new pair overwrites an unaccepted pair.

Behaviour:
- Reset, asynchronous: all outputs 0, synchronizers 0, FSM in IDLE, bit counter 0, shift register 0.
- Synchronization:
  - bclk, adclrc and adcdat each pass through SYNC_STAGES flops, so all three stay mutually aligned.
  - A further flop on synced bclk gives bclk_d.
  - rise = bclk_s & ~bclk_d. All capture actions happen only in rise cycles.
- Word-select tracking: on each rise, lrc_prev <= lrc_s. A slot boundary is a rise with lrc_s != lrc_prev. The boundary rise is the I2S one-bit delay slot, and no data is captured on it.
- FSM states:
  - IDLE: wait for a boundary with lrc_s = 0 (left start), then go to SHIFT with cnt = 0. Right-first boundaries after reset are ignored.
  - SHIFT: on each non-boundary rise, shift in adcdat_s as LSB and increment cnt.
    - When cnt reaches DATA_WIDTH, latch the word into the left or right holding register according to lrc_s, then go to WAIT.
    - A boundary while in SHIFT means a short slot: drop the partial word, pulse frame_err, mark the pair invalid, and restart SHIFT with cnt = 0 for the new channel.
  - WAIT: ignore rises until a boundary, then go to SHIFT with cnt = 0.
- Pairing:
  - A latched left word sets left_ok; a latched right word completes the pair only if left_ok is set.
  - Completing a pair copies both holding registers to out_left/out_right and sets out_valid on the next mclk edge. Latency from the rise cycle capturing the right LSB to out_valid = 1 mclk.
  - left_ok clears on pair completion, on frame_err, and when a left slot starts.
- Handshake:
  - out_valid falls the cycle after an accept.
  - If a pair completes while out_valid = 1 and the pair is not accepted that same cycle: overwrite out_left/out_right, keep out_valid = 1, pulse overrun.
  - Completion and accept in the same cycle: the new pair loads, out_valid stays 1, no overrun.
- Outputs are stable while out_valid = 1 and no new pair completes.
- Reset mid-word: all state is discarded, the FSM returns to IDLE, and capture restarts at the next left boundary.
- bclk stopped: the FSM holds state indefinitely, with no timeout.

Test Plan:
- Reset, then a standard frame (32 bclk per slot, MSB one bclk after the adclrc fall); left 16'hA5C3, right 16'h1234, out_ready = 1 -> out_valid pulses 1 mclk with out_left = A5C3, out_right = 1234; frame_err = 0, overrun = 0.
- Ten consecutive frames with out_ready = 1 -> ten accepted pairs in order, each matching driven data; out_valid asserts once per frame.
- out_ready = 0 for two frames (8000/0001, then 7FFF/FFFF) -> overrun pulses once; outputs = 7FFF/FFFF; raising ready accepts exactly one pair.
- adclrc toggles after 10 bits of a left slot -> frame_err pulses; that frame's right word (say 5555) produces no out_valid; the following full frame pairs correctly.
- Reset released while adclrc = 1 mid right slot -> nothing emitted until the first left boundary; the next full frame is emitted intact.
- Assert rst for 1 mclk mid-SHIFT with out_valid = 1 -> out_valid and all outputs go 0 immediately (asynchronously); the next complete frame is captured correctly.
